// File: rtl/sobel_ctrl.sv
// rtl/sobel_ctrl.sv - Sobel frame sequencer (optional border fill: SOBEL_BORDER_FILL_EN)
module sobel_ctrl #(
    parameter int         H_ACTIVE    = 640,
    parameter int         V_ACTIVE    = 480,
    parameter int         PIPE_LAT    = 6,
    parameter logic [7:0] THRESH_INIT = 8'd100
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       iFVAL,
    input  logic       iDVAL,
    input  logic [7:0] iTHRESH,
    input  logic       iTHRESH_WR,
    input  logic [9:0] iSOBEL_DATA,
    output logic       oDP_EN,
    output logic [7:0] oTHRESH,
    output logic [9:0] oDATA,
    output logic       oDVAL,
    output logic       oFRAME_DONE,
    output logic       oBUSY
);

    localparam int XW = $clog2(H_ACTIVE + 1);
    localparam int YW = $clog2(V_ACTIVE + 1);
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_END  = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);
    localparam logic [DW-1:0] D_LAST = DW'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                fval_d;
    logic [XW-1:0]       x_cnt;
    logic [YW-1:0]       y_cnt;
    logic [DW-1:0]       drain_cnt;
    logic [7:0]          thresh_pend;
    logic [PIPE_LAT-1:0] pipe_acc;
    logic [PIPE_LAT-1:0] pipe_win;
    logic                dp_en;
    logic                in_win;
    logic                frame_start;
    logic                drain_done;
    logic                acc_tap;
    logic                win_tap;

    assign frame_start = (state == S_IDLE) && iFVAL && !fval_d;
    assign drain_done  = (state == S_DRAIN) && (drain_cnt == D_LAST);
    assign dp_en       = iDVAL && (state == S_ACTIVE) && (y_cnt < Y_END);
    assign in_win      = (x_cnt >= X_TWO) && (y_cnt >= Y_TWO);
    assign acc_tap     = pipe_acc[PIPE_LAT-1];
    assign win_tap     = pipe_win[PIPE_LAT-1];
    assign oDP_EN      = dp_en;

    // Next-state decode: start on a sampled rising edge, drain after iFVAL drops
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (frame_start) state_nxt = S_ACTIVE;
            S_ACTIVE: if (!iFVAL)      state_nxt = S_DRAIN;
            S_DRAIN:  if (drain_done)  state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    // State register with registered busy flag and end-of-frame pulse
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state       <= S_IDLE;
            oBUSY       <= 1'b0;
            oFRAME_DONE <= 1'b0;
        end else begin
            state       <= state_nxt;
            oBUSY       <= (state_nxt != S_IDLE);
            oFRAME_DONE <= drain_done;
        end
    end

    // Previous iFVAL sample; resets high so a frame already in progress is skipped
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) fval_d <= 1'b1;
        else          fval_d <= iFVAL;
    end

    // Drain timer runs only while the pipeline empties
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N)              drain_cnt <= '0;
        else if (state != S_DRAIN) drain_cnt <= '0;
        else                       drain_cnt <= drain_cnt + DW'(1);
    end

    // Pixel column/row tracking; row saturates at V_ACTIVE because dp_en drops there
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (frame_start) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (dp_en) begin
            if (x_cnt == X_LAST) begin
                x_cnt <= '0;
                y_cnt <= y_cnt + YW'(1);
            end else begin
                x_cnt <= x_cnt + XW'(1);
            end
        end
    end

    // Threshold: writes land in the pending copy, the live copy moves only at frame start
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            thresh_pend <= THRESH_INIT;
            oTHRESH     <= THRESH_INIT;
        end else begin
            if (iTHRESH_WR)  thresh_pend <= iTHRESH;
            if (frame_start) oTHRESH     <= iTHRESH_WR ? iTHRESH : thresh_pend;
        end
    end

    // Latency-matching delay line for {accepted, in-window}
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pipe_acc <= '0;
            pipe_win <= '0;
        end else begin
            pipe_acc <= (pipe_acc << 1) | PIPE_LAT'(dp_en);
            pipe_win <= (pipe_win << 1) | PIPE_LAT'(dp_en && in_win);
        end
    end

    // Output realignment; oDATA holds its value whenever oDVAL is low
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            oDATA <= '0;
            oDVAL <= 1'b0;
        end else if (acc_tap && win_tap) begin
            oDATA <= iSOBEL_DATA;
            oDVAL <= 1'b1;
`ifdef SOBEL_BORDER_FILL_EN
        end else if (acc_tap) begin
            oDATA <= 10'h3FF;
            oDVAL <= 1'b1;
`endif
        end else begin
            oDVAL <= 1'b0;
        end
    end

endmodule
